// File: rtl/cp0_pkg.sv
// +-----------------------------------------------------------------+
// | cp0_pkg: register map, field positions and ExcCodes for CP0     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package cp0_pkg;

  typedef enum logic [4:0] {
    CP0_COUNT   = 5'd9,
    CP0_COMPARE = 5'd11,
    CP0_SR      = 5'd12,
    CP0_CAUSE   = 5'd13,
    CP0_EPC     = 5'd14,
    CP0_PRID    = 5'd15
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_W  = 5;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;
  localparam int MAX_HWINT    = 6;

  // Return address: the branch owning the delay slot sits one word earlier.
  function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic in_delay_slot);
    logic [31:0] aligned;
    aligned = pc & 32'hFFFF_FFFC;
    return in_delay_slot ? (aligned - 32'd4) : aligned;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// +-----------------------------------------------------------------+
// | cp0_timer: free-running Count, Compare and the pending flag     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pend
);

  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [31:0] compare_q;
  logic [31:0] compare_d;
  logic        pend_q;
  logic        pend_d;
  logic        match;

  assign match = (count_q == compare_q);

  always_comb begin
    count_d   = count_we ? wdata : (count_q + 32'd1);
    compare_d = compare_we ? wdata : compare_q;
    // A Compare write acknowledges the timer even if it also matches now.
    if (compare_we) begin
      pend_d = 1'b0;
    end else if (match) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign pend    = pend_q;

endmodule

`default_nettype wire

// File: rtl/cp0_intc.sv
// +-----------------------------------------------------------------+
// | cp0_intc: M-stage CP0 with level/edge interrupt controller      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT  = 6,
  parameter logic [5:0]  EDGE_MASK  = 6'b000000,
  parameter bit          TIMER_EN   = 1'b1,
  parameter int          TIMER_LINE = 5,
  parameter logic [31:0] PRID       = 32'h0000_0913
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           cp0_addr,
  input  logic [31:0]          cp0_in,
  output logic [31:0]          cp0_out,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code_in,
  input  logic [31:0]          vpc,
  input  logic                 exl_clr,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic [31:0]          epc_out,
  output logic                 req,
  output logic                 timer_irq
);

  localparam logic [NUM_HWINT-1:0] EDGE_LINES = EDGE_MASK[NUM_HWINT-1:0];

  // SR
  logic                 ie_q, ie_d;
  logic                 exl_q, exl_d;
  logic [NUM_HWINT-1:0] im_q, im_d;
  // Cause
  logic                 bd_q, bd_d;
  logic [4:0]           code_q, code_d;
  // EPC
  logic [31:0]          epc_q, epc_d;
  // Edge detection
  logic [NUM_HWINT-1:0] edge_q, edge_d;
  logic [NUM_HWINT-1:0] prev_q, prev_d;
  logic [NUM_HWINT-1:0] ip_clr;

  logic [NUM_HWINT-1:0] ip;
  logic                 int_pend;
  logic                 exc_pend;
  logic                 take;
  logic                 wr;
  logic                 wr_sr, wr_cause, wr_epc, wr_count, wr_compare;

  logic [31:0]          timer_count;
  logic [31:0]          timer_compare;
  logic                 timer_pend;

  logic [31:0]          sr_rd;
  logic [31:0]          cause_rd;
  logic [31:0]          rd_data;

  // ---------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------
  if (TIMER_EN) begin : g_timer
    cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (wr_count),
      .compare_we (wr_compare),
      .wdata      (cp0_in),
      .count      (timer_count),
      .compare    (timer_compare),
      .pend       (timer_pend)
    );
  end else begin : g_no_timer
    assign timer_count   = 32'd0;
    assign timer_compare = 32'd0;
    assign timer_pend    = 1'b0;
  end

  // ---------------------------------------------------------------
  // Interrupt pending bits
  // ---------------------------------------------------------------
  for (genvar i = 0; i < NUM_HWINT; i++) begin : g_ip
    logic src;
    assign src = EDGE_LINES[i] ? edge_q[i] : hwint[i];
    if (TIMER_EN && (i == TIMER_LINE)) begin : g_tmr_line
      assign ip[i] = src | timer_pend;
    end else begin : g_plain_line
      assign ip[i] = src;
    end
  end

  // ---------------------------------------------------------------
  // Arbitration and write decode
  // ---------------------------------------------------------------
  assign int_pend = (|(ip & im_q)) & ie_q & ~exl_q;
  assign exc_pend = (exc_code_in != 5'd0) & ~exl_q;
  assign take     = int_pend | exc_pend;

  // The instruction issuing mtc0 is being flushed when take is high.
  assign wr         = en & ~take;
  assign wr_sr      = wr & (cp0_addr == CP0_SR);
  assign wr_cause   = wr & (cp0_addr == CP0_CAUSE);
  assign wr_epc     = wr & (cp0_addr == CP0_EPC);
  assign wr_count   = wr & (cp0_addr == CP0_COUNT);
  assign wr_compare = wr & (cp0_addr == CP0_COMPARE);

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    im_d   = im_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;

    if (wr_sr) begin
      ie_d  = cp0_in[SR_IE];
      exl_d = cp0_in[SR_EXL];
      im_d  = cp0_in[SR_IM_LO +: NUM_HWINT];
    end
    if (wr_epc) begin
      epc_d = cp0_in;
    end
    if (exl_clr) begin
      exl_d = 1'b0;
    end
    if (take) begin
      exl_d  = 1'b1;
      bd_d   = bd_in;
      code_d = int_pend ? EXC_INT : exc_code_in;
      epc_d  = exc_epc(vpc, bd_in);
    end
  end

  // Set wins over a coincident W1C clear.
  always_comb begin
    ip_clr = wr_cause ? cp0_in[CAUSE_IP_LO +: NUM_HWINT] : '0;
    edge_d = ((edge_q & ~ip_clr) | (hwint & ~prev_q)) & EDGE_LINES;
    prev_d = hwint;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      im_q   <= '0;
      bd_q   <= 1'b0;
      code_q <= 5'd0;
      epc_q  <= 32'd0;
      edge_q <= '0;
      prev_q <= '0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      im_q   <= im_d;
      bd_q   <= bd_d;
      code_q <= code_d;
      epc_q  <= epc_d;
      edge_q <= edge_d;
      prev_q <= prev_d;
    end
  end

  // ---------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------
  always_comb begin
    sr_rd                              = 32'd0;
    sr_rd[SR_IE]                       = ie_q;
    sr_rd[SR_EXL]                      = exl_q;
    sr_rd[SR_IM_LO +: NUM_HWINT]       = im_q;

    cause_rd                           = 32'd0;
    cause_rd[CAUSE_BD]                 = bd_q;
    cause_rd[CAUSE_IP_LO +: NUM_HWINT] = ip;
    cause_rd[CAUSE_EXC_LO +: CAUSE_EXC_W] = code_q;
  end

  always_comb begin
    rd_data = 32'd0;
    case (cp0_addr)
      CP0_COUNT:   rd_data = timer_count;
      CP0_COMPARE: rd_data = timer_compare;
      CP0_SR:      rd_data = sr_rd;
      CP0_CAUSE:   rd_data = cause_rd;
      CP0_EPC:     rd_data = epc_q;
      CP0_PRID:    rd_data = PRID;
      default:     rd_data = 32'd0;
    endcase
  end

  assign cp0_out   = reset ? 32'd0 : rd_data;
  assign req       = take & ~reset;
  assign timer_irq = timer_pend & ~reset;
  assign epc_out   = epc_q;

endmodule

`default_nettype wire

// File: tb/tb_cp0_intc.sv
// +-----------------------------------------------------------------+
// | tb_cp0_intc: directed + randomized bench with reference model   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_cp0_intc;

  localparam int          NH     = 6;
  localparam logic [5:0]  EMASK  = 6'b000100;
  localparam int          TLINE  = 5;
  localparam logic [31:0] PRID_V = 32'h0000_0913;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  cp0_addr = 5'd0;
  logic [31:0] cp0_in = 32'd0;
  logic [31:0] cp0_out;
  logic        bd_in = 1'b0;
  logic [4:0]  exc_code_in = 5'd0;
  logic [31:0] vpc = 32'd0;
  logic        exl_clr = 1'b0;
  logic [NH-1:0] hwint = '0;
  logic [31:0] epc_out;
  logic        req;
  logic        timer_irq;

  cp0_intc #(
    .NUM_HWINT  (NH),
    .EDGE_MASK  (EMASK),
    .TIMER_EN   (1'b1),
    .TIMER_LINE (TLINE),
    .PRID       (PRID_V)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cp0_addr    (cp0_addr),
    .cp0_in      (cp0_in),
    .cp0_out     (cp0_out),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .vpc         (vpc),
    .exl_clr     (exl_clr),
    .hwint       (hwint),
    .epc_out     (epc_out),
    .req         (req),
    .timer_irq   (timer_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  // Architectural state of the reference model
  bit        m_ie, m_exl, m_bd, m_tpend;
  bit [5:0]  m_im, m_lat, m_prev;
  bit [4:0]  m_code;
  bit [31:0] m_epc, m_count, m_compare;
  bit [5:0]  emask = EMASK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit [5:0] m_ip();
    bit [5:0] v;
    for (int i = 0; i < NH; i++) v[i] = emask[i] ? m_lat[i] : hwint[i];
    v[TLINE] = v[TLINE] | m_tpend;
    return v;
  endfunction

  function automatic bit m_int();
    return ((m_ip() & m_im) != 6'd0) && m_ie && !m_exl;
  endfunction

  function automatic bit m_exc();
    return (exc_code_in != 5'd0) && !m_exl;
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ip()) << 10) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit intr, take, wr, match;
    bit [5:0] clr;
    if (reset) begin
      m_ie = 0; m_exl = 0; m_bd = 0; m_tpend = 0;
      m_im = 0; m_lat = 0; m_prev = 0; m_code = 0;
      m_epc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;
    end else begin
      intr  = m_int();
      take  = intr || m_exc();
      wr    = en && !take;
      match = (m_count == m_compare);
      clr   = (wr && cp0_addr == 5'd13) ? cp0_in[15:10] : 6'd0;
      m_lat  = ((m_lat & ~clr) | (hwint & ~m_prev)) & emask;
      m_prev = hwint;
      if (wr && cp0_addr == 5'd11) begin
        m_compare = cp0_in;
        m_tpend   = 0;
      end else if (match) begin
        m_tpend = 1;
      end
      m_count = (wr && cp0_addr == 5'd9) ? cp0_in : m_count + 32'd1;
      if (wr && cp0_addr == 5'd12) begin
        m_ie  = cp0_in[0];
        m_exl = cp0_in[1];
        m_im  = cp0_in[15:10];
      end
      if (wr && cp0_addr == 5'd14) m_epc = cp0_in;
      if (exl_clr) m_exl = 0;
      if (take) begin
        m_exl  = 1;
        m_bd   = bd_in;
        m_code = intr ? 5'd0 : exc_code_in;
        m_epc  = (vpc & 32'hFFFF_FFFC) - (bd_in ? 32'd4 : 32'd0);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Output compare, every cycle once reset has been applied
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("req", {31'd0, req}, {31'd0, !reset && (m_int() || m_exc())});
      chk("cp0_out", cp0_out, reset ? 32'd0 : m_read(cp0_addr));
      chk("epc_out", epc_out, m_epc);
      chk("timer_irq", {31'd0, timer_irq}, {31'd0, !reset && m_tpend});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; cp0_addr = a; cp0_in = d;
    tick();
    en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(nm, cp0_out, exp);
  endtask

  initial begin
    // 1. reset values
    tick();
    cmp_on = 1'b1;
    cp0_addr = 5'd15;
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_cp0_out", cp0_out, 32'd0);
    chk("rst_timer_irq", {31'd0, timer_irq}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    rd_chk("t1_sr", 5'd12, 32'd0);
    rd_chk("t1_cause", 5'd13, 32'd0);
    rd_chk("t1_epc", 5'd14, 32'd0);
    rd_chk("t1_prid", 5'd15, PRID_V);
    rd_chk("t1_compare", 5'd11, 32'hFFFF_FFFF);

    // 2. level interrupt
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; vpc = 32'h3010; bd_in = 1'b0;
    #1;
    chk("t2_req", {31'd0, req}, 32'd1);
    tick();
    rd_chk("t2_epc", 5'd14, 32'h3010);
    rd_chk("t2_cause", 5'd13, 32'h0000_0400);
    rd_chk("t2_sr", 5'd12, 32'h0000_0403);
    hwint = '0; exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;

    // 3. exception in delay slot with IE=0
    mtc0(5'd12, 32'd0);
    exc_code_in = 5'd12; bd_in = 1'b1; vpc = 32'h3024;
    #1;
    chk("t3_req", {31'd0, req}, 32'd1);
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0;
    rd_chk("t3_epc", 5'd14, 32'h3020);
    rd_chk("t3_cause", 5'd13, 32'h8000_0030);
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;

    // 4. edge-triggered line 2
    hwint = 6'b000100;
    tick();
    hwint = '0;
    tick();
    rd_chk("t4_latched", 5'd13, 32'h8000_1030);
    mtc0(5'd13, 32'h0000_1000);
    rd_chk("t4_cleared", 5'd13, 32'h8000_0030);
    en = 1'b1; cp0_addr = 5'd13; cp0_in = 32'h0000_1000; hwint = 6'b000100;
    tick();
    en = 1'b0; hwint = '0;
    rd_chk("t4_set_wins", 5'd13, 32'h8000_1030);
    mtc0(5'd13, 32'h0000_1000);

    // 5. timer
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("t5_req_c%0d", k), {31'd0, req}, (k == 7) ? 32'd1 : 32'd0);
      if (k < 7) tick();
    end
    chk("t5_timer_irq", {31'd0, timer_irq}, 32'd1);
    tick();
    mtc0(5'd11, 32'hFFFF_FFFF);
    chk("t5_irq_cleared", {31'd0, timer_irq}, 32'd0);
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    mtc0(5'd12, 32'd0);
    mtc0(5'd11, 32'd2);
    mtc0(5'd9, 32'hFFFF_FFFE);
    rd_chk("t5_count_ld", 5'd9, 32'hFFFF_FFFE);
    tick();
    tick();
    rd_chk("t5_count_wrap", 5'd9, 32'd0);
    tick(); tick(); tick();
    chk("t5_wrap_irq", {31'd0, timer_irq}, 32'd1);
    mtc0(5'd11, 32'hFFFF_FFFF);

    // 6. interrupt beats exception; mtc0 dropped; exl_clr re-arms
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; exc_code_in = 5'd4; vpc = 32'h4000; bd_in = 1'b0;
    en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'hDEAD_BEE0;
    #1;
    chk("t6_req", {31'd0, req}, 32'd1);
    tick();
    en = 1'b0; exc_code_in = 5'd0;
    cp0_addr = 5'd13;
    #1;
    chk("t6_exccode", {27'd0, cp0_out[6:2]}, 32'd0);
    rd_chk("t6_epc_kept", 5'd14, 32'h4000);
    exl_clr = 1'b1;
    #1;
    chk("t6_req_in_eret", {31'd0, req}, 32'd0);
    tick();
    exl_clr = 1'b0;
    #1;
    chk("t6_req_after", {31'd0, req}, 32'd1);
    hwint = '0;
    #1;
    mtc0(5'd12, 32'd0);

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      int r;
      logic [4:0] wa;
      r = $urandom_range(0, 99);
      reset = (r == 0);
      if ($urandom_range(0, 3) == 0) hwint = NH'($urandom);
      exc_code_in = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      exl_clr     = ($urandom_range(0, 5) == 0);
      bd_in       = 1'($urandom);
      vpc         = $urandom;
      en          = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 6))
        0: wa = 5'd9;
        1: wa = 5'd11;
        2: wa = 5'd12;
        3: wa = 5'd13;
        4: wa = 5'd14;
        5: wa = 5'd15;
        default: wa = 5'($urandom);
      endcase
      cp0_addr = wa;
      if (wa == 5'd11 && $urandom_range(0, 1) == 0)
        cp0_in = m_count + 32'($urandom_range(1, 20));
      else if (wa == 5'd9 && $urandom_range(0, 3) == 0)
        cp0_in = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        cp0_in = $urandom;
      tick();
    end
    reset = 1'b0;
    en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
